// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clk_div_gen programmable clock divider.
package clk_div_pkg;

  localparam int CLK_DIV_WIDTH_DEF = 16;
  localparam int CLK_DIV_RESET_DEF = 2;

  // Divisor arithmetic is done at 32 bits so one helper serves every WIDTH up to 32.
  function automatic logic [31:0] eff_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/clk_div_shadow.sv
// Holds a requested divisor until the next apply edge (period wrap or disabled cycle).
module clk_div_shadow
  import clk_div_pkg::*;
#(
  parameter int WIDTH = CLK_DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  input  logic             apply,
  output logic [WIDTH-1:0] div_shadow,
  output logic             div_pend
);

  logic [WIDTH-1:0] shadow_reg;
  logic             pend_reg;

  // A load on the apply edge bypasses the shadow, so the flag never rises for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg <= '0;
      pend_reg   <= 1'b0;
    end else if (apply) begin
      pend_reg   <= 1'b0;
    end else if (div_load) begin
      shadow_reg <= div_in;
      pend_reg   <= 1'b1;
    end
  end

  assign div_shadow = shadow_reg;
  assign div_pend   = pend_reg;

endmodule

// File: rtl/clk_div_gen.sv
// Runtime-programmable clock divider producing a tick strobe and a 50% square wave.
// Optional tick counter output enabled by defining CLK_DIV_GEN_PCNT_EN.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int WIDTH      = CLK_DIV_WIDTH_DEF,
  parameter int DIV_RESET  = CLK_DIV_RESET_DEF,
  parameter int PCNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WIDTH-1:0]      div_in,
  input  logic                  div_load,
  output logic [WIDTH-1:0]      div_cur,
  output logic                  div_pend,
  output logic                  tick,
  output logic                  clk_out
`ifdef CLK_DIV_GEN_PCNT_EN
  ,
  output logic [PCNT_WIDTH-1:0] pcnt
`endif
);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] div_cur_reg;
  logic [WIDTH-1:0] div_cur_next;
  logic [WIDTH-1:0] div_shadow;
  logic             pend;
  logic             tick_reg;
  logic             clk_out_reg;
  logic [31:0]      div_eff;
  logic             wrap;
  logic             apply;

  assign div_eff = eff_div(32'(div_cur_reg));
  assign wrap    = en && (32'(cnt_reg) == (div_eff - 32'd1));
  // Disabled cycles are safe points to switch divisor since the counter restarts anyway.
  assign apply   = wrap || !en;

  clk_div_shadow #(
    .WIDTH (WIDTH)
  ) u_shadow (
    .clk        (clk),
    .rst        (rst),
    .div_in     (div_in),
    .div_load   (div_load),
    .apply      (apply),
    .div_shadow (div_shadow),
    .div_pend   (pend)
  );

  always_comb begin
    cnt_next = cnt_reg + WIDTH'(1);
    if (apply) begin
      cnt_next = '0;
    end
  end

  always_comb begin
    div_cur_next = div_cur_reg;
    if (apply) begin
      if (div_load) begin
        div_cur_next = div_in;
      end else if (pend) begin
        div_cur_next = div_shadow;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      div_cur_reg <= WIDTH'(DIV_RESET);
      tick_reg    <= 1'b0;
      clk_out_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      div_cur_reg <= div_cur_next;
      tick_reg    <= wrap;
      if (wrap) begin
        clk_out_reg <= ~clk_out_reg;
      end
    end
  end

  assign div_cur  = div_cur_reg;
  assign div_pend = pend;
  assign tick     = tick_reg;
  assign clk_out  = clk_out_reg;

`ifdef CLK_DIV_GEN_PCNT_EN
  logic [PCNT_WIDTH-1:0] pcnt_reg;

  // Advances in step with tick so pcnt always equals the number of ticks seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_reg <= '0;
    end else if (wrap) begin
      pcnt_reg <= pcnt_reg + PCNT_WIDTH'(1);
    end
  end

  assign pcnt = pcnt_reg;
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen; pcnt checks are compiled in with CLK_DIV_GEN_PCNT_EN.
module tb_clk_div_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] div_in;
  logic        div_load;
  logic [15:0] div_cur;
  logic        div_pend;
  logic        tick;
  logic        clk_out;
`ifdef CLK_DIV_GEN_PCNT_EN
  logic [2:0]  pcnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clk_div_gen #(
    .WIDTH      (16),
    .DIV_RESET  (2),
    .PCNT_WIDTH (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .div_cur  (div_cur),
    .div_pend (div_pend),
    .tick     (tick),
    .clk_out  (clk_out)
`ifdef CLK_DIV_GEN_PCNT_EN
    ,
    .pcnt     (pcnt)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expo(input string tag, input logic t, input logic c,
                      input logic [15:0] d, input logic p);
    chk({tag, ".tick"},     32'(tick),     32'(t));
    chk({tag, ".clk_out"},  32'(clk_out),  32'(c));
    chk({tag, ".div_cur"},  32'(div_cur),  32'(d));
    chk({tag, ".div_pend"}, 32'(div_pend), 32'(p));
    $display("step %-10s tick=%0d clk_out=%0d div_cur=%0d div_pend=%0d",
             tag, tick, clk_out, div_cur, div_pend);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_in = '0; div_load = 1'b0;
    repeat (2) cyc();
    expo("reset", 0, 0, 2, 0);
`ifdef CLK_DIV_GEN_PCNT_EN
    chk("reset.pcnt", 32'(pcnt), 32'd0);
`endif

    // Default divisor 2: tick after edges 2,4,6; clk_out rises at 2, falls at 4
    rst = 1'b0; en = 1'b1;
    cyc(); expo("t1_e1", 0, 0, 2, 0);
    cyc(); expo("t1_e2", 1, 1, 2, 0);
    cyc(); expo("t1_e3", 0, 1, 2, 0);
    cyc(); expo("t1_e4", 1, 0, 2, 0);
    cyc(); expo("t1_e5", 0, 0, 2, 0);
    cyc(); expo("t1_e6", 1, 1, 2, 0);

    // Divisor 1 loaded while disabled: clk/2 toggle
    en = 1'b0; div_in = 16'd1; div_load = 1'b1;
    cyc(); div_load = 1'b0; expo("t2_load", 0, 1, 1, 0);
    en = 1'b1;
    cyc(); expo("t2_e1", 1, 0, 1, 0);
    cyc(); expo("t2_e2", 1, 1, 1, 0);
    cyc(); expo("t2_e3", 1, 0, 1, 0);
    cyc(); expo("t2_e4", 1, 1, 1, 0);

    // D=5, load 3 at cnt=1: pending until the wrap, then 3-cycle period
    en = 1'b0; div_in = 16'd5; div_load = 1'b1;
    cyc(); div_load = 1'b0; expo("t3_load5", 0, 1, 5, 0);
    en = 1'b1;
    cyc(); expo("t3_c1", 0, 1, 5, 0);
    div_in = 16'd3; div_load = 1'b1;
    cyc(); div_load = 1'b0; expo("t3_c2", 0, 1, 5, 1);
    cyc(); expo("t3_c3", 0, 1, 5, 1);
    cyc(); expo("t3_c4", 0, 1, 5, 1);
    cyc(); expo("t3_wrap", 1, 0, 3, 0);
    cyc(); expo("t3_n1", 0, 0, 3, 0);
    cyc(); expo("t3_n2", 0, 0, 3, 0);
    cyc(); expo("t3_n3", 1, 1, 3, 0);

    // Load of 0 coinciding with a wrap: applied directly, then tick every cycle
    cyc(); expo("t4_c1", 0, 1, 3, 0);
    cyc(); expo("t4_c2", 0, 1, 3, 0);
    div_in = 16'd0; div_load = 1'b1;
    cyc(); div_load = 1'b0; expo("t4_wrap", 1, 0, 0, 0);
    cyc(); expo("t4_e1", 1, 1, 0, 0);
    cyc(); expo("t4_e2", 1, 0, 0, 0);
    cyc(); expo("t4_e3", 1, 1, 0, 0);

    // Two loads while pending (last wins), applied when en drops
    en = 1'b0; div_in = 16'd4; div_load = 1'b1;
    cyc(); div_load = 1'b0; expo("t5_load4", 0, 1, 4, 0);
    en = 1'b1;
    cyc(); expo("t5_c1", 0, 1, 4, 0);
    div_in = 16'd6; div_load = 1'b1;
    cyc(); expo("t5_ld6", 0, 1, 4, 1);
    div_in = 16'd7;
    cyc(); div_load = 1'b0; expo("t5_ld7", 0, 1, 4, 1);
    en = 1'b0;
    cyc(); expo("t5_dis", 0, 1, 7, 0);

    // D=8, reset at cnt=3 overriding a simultaneous load
    div_in = 16'd8; div_load = 1'b1;
    cyc(); div_load = 1'b0; expo("t6_load8", 0, 1, 8, 0);
    en = 1'b1;
    cyc(); expo("t6_c1", 0, 1, 8, 0);
    cyc(); expo("t6_c2", 0, 1, 8, 0);
    cyc(); expo("t6_c3", 0, 1, 8, 0);
    rst = 1'b1; div_in = 16'd7; div_load = 1'b1;
    cyc(); rst = 1'b0; div_load = 1'b0; expo("t6_rst", 0, 0, 2, 0);
`ifdef CLK_DIV_GEN_PCNT_EN
    chk("t6_rst.pcnt", 32'(pcnt), 32'd0);
`endif
    cyc(); expo("t6_r1", 0, 0, 2, 0);
    cyc(); expo("t6_r2", 1, 1, 2, 0);
    cyc(); expo("t6_r3", 0, 1, 2, 0);

    // en low for 4 cycles: counter restarts, clk_out holds
    en = 1'b0;
    cyc(); expo("t7_d1", 0, 1, 2, 0);
    cyc(); expo("t7_d2", 0, 1, 2, 0);
    cyc(); expo("t7_d3", 0, 1, 2, 0);
    cyc(); expo("t7_d4", 0, 1, 2, 0);
    en = 1'b1;
    cyc(); expo("t7_e1", 0, 1, 2, 0);
    cyc(); expo("t7_e2", 1, 0, 2, 0);

`ifdef CLK_DIV_GEN_PCNT_EN
    // 3-bit tick counter at D=1 wraps to 0 after 8 ticks
    rst = 1'b1;
    cyc(); rst = 1'b0; en = 1'b0; div_in = 16'd1; div_load = 1'b1;
    cyc(); div_load = 1'b0; en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk($sformatf("t8_pcnt%0d", i), 32'(pcnt), 32'(i % 8));
      $display("step t8_pcnt%0d pcnt=%0d", i, pcnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
